// File: rtl/branch_resolver.sv
// Resolves a conditional branch (direction, next PC, mispredict) and keeps retire statistics.
// Latency 1 cycle; a 2-entry skid buffer lets out_ready be registered and sustain 1 entry/cycle.
module branch_resolver #(
  parameter int DATA_WIDTH = 64,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  in_clk,
  input  logic                  in_rst_n,
  input  logic                  in_valid,
  output logic                  out_ready,
  input  logic [4:0]            in_flag,
  input  logic [2:0]            in_funct3,
  input  logic                  in_is_branch,
  input  logic                  in_pred_taken,
  input  logic [DATA_WIDTH-1:0] in_pc,
  input  logic [DATA_WIDTH-1:0] in_offset,
  input  logic                  in_flush,
  output logic                  out_valid,
  input  logic                  in_ready,
  output logic                  out_taken,
  output logic [DATA_WIDTH-1:0] out_target,
  output logic                  out_mispredict,
  output logic                  out_illegal,
  output logic [CNT_WIDTH-1:0]  out_br_count,
  output logic [CNT_WIDTH-1:0]  out_mispred_count
);

  typedef struct packed {
    logic                  is_branch;
    logic                  taken;
    logic                  mispredict;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] target;
  } ent_t;

  ent_t                 m_ent, s_ent, new_ent;
  logic                 m_vld, s_vld;
  logic                 cond, illegal_code;
  logic                 accept, drain;
  logic [CNT_WIDTH-1:0] br_cnt, mp_cnt;

  // flag bits are {EQ, LT, LTU, GE, GEU}
  always_comb begin
    cond         = 1'b0;
    illegal_code = 1'b0;
    case (in_funct3)
      3'b000:  cond = in_flag[4];
      3'b001:  cond = ~in_flag[4];
      3'b100:  cond = in_flag[3];
      3'b101:  cond = in_flag[1];
      3'b110:  cond = in_flag[2];
      3'b111:  cond = in_flag[0];
      default: illegal_code = 1'b1;
    endcase
  end

  always_comb begin
    new_ent            = '0;
    new_ent.is_branch  = in_is_branch;
    new_ent.taken      = in_is_branch & cond;
    new_ent.illegal    = in_is_branch & illegal_code;
    new_ent.mispredict = in_is_branch & (new_ent.taken ^ in_pred_taken);
    new_ent.target     = new_ent.taken ? (in_pc + in_offset) : (in_pc + DATA_WIDTH'(4));
  end

  assign out_ready = ~s_vld;
  assign accept    = in_valid & out_ready & ~in_flush;
  assign drain     = m_vld & in_ready;

  // S only fills while M is stalled, so S valid implies M valid and no accept.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
      m_ent <= '0;
      s_ent <= '0;
    end else if (in_flush) begin
      m_vld <= 1'b0;
      s_vld <= 1'b0;
    end else if (s_vld && drain) begin
      m_ent <= s_ent;
      s_vld <= 1'b0;
    end else if (accept && (!m_vld || drain)) begin
      m_ent <= new_ent;
      m_vld <= 1'b1;
    end else if (accept) begin
      s_ent <= new_ent;
      s_vld <= 1'b1;
    end else if (drain) begin
      m_vld <= 1'b0;
    end
  end

  // Statistics count retirements, so a handshake in a flush cycle still counts.
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else if (drain && m_ent.is_branch) begin
      if (br_cnt != '1) br_cnt <= br_cnt + CNT_WIDTH'(1);
      if (m_ent.mispredict && (mp_cnt != '1)) mp_cnt <= mp_cnt + CNT_WIDTH'(1);
    end
  end

  assign out_valid         = m_vld;
  assign out_taken         = m_ent.taken;
  assign out_target        = m_ent.target;
  assign out_mispredict    = m_ent.mispredict;
  assign out_illegal       = m_ent.illegal;
  assign out_br_count      = br_cnt;
  assign out_mispred_count = mp_cnt;

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver; a second instance with 2-bit counters exercises saturation.
module tb_branch_resolver;

  logic        in_clk = 1'b0;
  logic        in_rst_n;
  logic        in_valid;
  logic [4:0]  in_flag;
  logic [2:0]  in_funct3;
  logic        in_is_branch;
  logic        in_pred_taken;
  logic [63:0] in_pc;
  logic [63:0] in_offset;
  logic        in_flush;
  logic        in_ready;

  logic        out_ready, out_valid, out_taken, out_mispredict, out_illegal;
  logic [63:0] out_target;
  logic [31:0] out_br_count, out_mispred_count;

  logic        s_ready, s_valid, s_taken, s_mispredict, s_illegal;
  logic [63:0] s_target;
  logic [1:0]  s_br_count, s_mispred_count;

  int vectors = 0;
  int errs    = 0;

  always #5 in_clk = ~in_clk;

  branch_resolver dut (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .out_ready(out_ready),
    .in_flag(in_flag), .in_funct3(in_funct3), .in_is_branch(in_is_branch),
    .in_pred_taken(in_pred_taken), .in_pc(in_pc), .in_offset(in_offset),
    .in_flush(in_flush), .out_valid(out_valid), .in_ready(in_ready),
    .out_taken(out_taken), .out_target(out_target), .out_mispredict(out_mispredict),
    .out_illegal(out_illegal), .out_br_count(out_br_count),
    .out_mispred_count(out_mispred_count)
  );

  branch_resolver #(.DATA_WIDTH(64), .CNT_WIDTH(2)) dut_sat (
    .in_clk(in_clk), .in_rst_n(in_rst_n), .in_valid(in_valid), .out_ready(s_ready),
    .in_flag(in_flag), .in_funct3(in_funct3), .in_is_branch(in_is_branch),
    .in_pred_taken(in_pred_taken), .in_pc(in_pc), .in_offset(in_offset),
    .in_flush(in_flush), .out_valid(s_valid), .in_ready(in_ready),
    .out_taken(s_taken), .out_target(s_target), .out_mispredict(s_mispredict),
    .out_illegal(s_illegal), .out_br_count(s_br_count),
    .out_mispred_count(s_mispred_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input logic t, input logic [63:0] tgt,
                         input logic mp, input logic il);
    chk({tag, ".valid"}, 64'(out_valid), 64'(v));
    chk({tag, ".taken"}, 64'(out_taken), 64'(t));
    chk({tag, ".target"}, out_target, tgt);
    chk({tag, ".mispred"}, 64'(out_mispredict), 64'(mp));
    chk({tag, ".illegal"}, 64'(out_illegal), 64'(il));
    chk({tag, ".sat_valid"}, 64'(s_valid), 64'(v));
    chk({tag, ".sat_taken"}, 64'(s_taken), 64'(t));
    chk({tag, ".sat_target"}, s_target, tgt);
    chk({tag, ".sat_mispred"}, 64'(s_mispredict), 64'(mp));
    chk({tag, ".sat_illegal"}, 64'(s_illegal), 64'(il));
  endtask

  task automatic chk_rdy(input string tag, input logic r);
    chk({tag, ".ready"}, 64'(out_ready), 64'(r));
    chk({tag, ".sat_ready"}, 64'(s_ready), 64'(r));
  endtask

  task automatic chk_cnt(input string tag, input int br, input int mp, input int sbr, input int smp);
    chk({tag, ".br_count"}, 64'(out_br_count), 64'(br));
    chk({tag, ".mp_count"}, 64'(out_mispred_count), 64'(mp));
    chk({tag, ".sat_br_count"}, 64'(s_br_count), 64'(sbr));
    chk({tag, ".sat_mp_count"}, 64'(s_mispred_count), 64'(smp));
  endtask

  task automatic put(input logic v, input logic [2:0] f3, input logic [4:0] fl, input logic br,
                     input logic pr, input logic [63:0] pc, input logic [63:0] off);
    in_valid      = v;
    in_funct3     = f3;
    in_flag       = fl;
    in_is_branch  = br;
    in_pred_taken = pr;
    in_pc         = pc;
    in_offset     = off;
  endtask

  task automatic tick;
    @(posedge in_clk);
    #1;
  endtask

  initial begin
    in_rst_n = 1'b0;
    in_flush = 1'b0;
    in_ready = 1'b1;
    put(1'b0, 3'b000, 5'b0, 1'b0, 1'b0, 64'h0, 64'h0);
    #2;
    chk_out("reset", 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk_rdy("reset", 1'b1);
    chk_cnt("reset", 0, 0, 0, 0);
    @(negedge in_clk);
    in_rst_n = 1'b1;

    // BEQ taken, predicted not-taken
    put(1'b1, 3'b000, 5'b10011, 1'b1, 1'b0, 64'h1000, 64'h20);
    tick;
    in_valid = 1'b0;
    chk_out("beq", 1'b1, 1'b1, 64'h1020, 1'b1, 1'b0);
    chk_cnt("beq_pre", 0, 0, 0, 0);
    tick;
    chk_out("beq_done", 1'b0, 1'b1, 64'h1020, 1'b1, 1'b0);
    chk_cnt("beq_done", 1, 1, 1, 1);

    // BLTU not-taken, PC+4 wraps to zero
    put(1'b1, 3'b110, 5'b00011, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h100);
    tick;
    in_valid = 1'b0;
    chk_out("bltu_wrap", 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
    tick;
    chk_cnt("bltu_wrap", 2, 1, 2, 1);

    // illegal code predicted taken
    put(1'b1, 3'b010, 5'b11111, 1'b1, 1'b1, 64'h2000, 64'h40);
    tick;
    in_valid = 1'b0;
    chk_out("illegal", 1'b1, 1'b0, 64'h2004, 1'b1, 1'b1);
    tick;
    chk_cnt("illegal", 3, 2, 3, 2);

    // non-branch: never counted
    put(1'b1, 3'b000, 5'b10000, 1'b0, 1'b1, 64'h3000, 64'h80);
    tick;
    in_valid = 1'b0;
    chk_out("nonbr", 1'b1, 1'b0, 64'h3004, 1'b0, 1'b0);
    tick;
    chk_cnt("nonbr", 3, 2, 3, 2);

    // backpressure: A -> M, B -> S, C held off
    in_ready = 1'b0;
    put(1'b1, 3'b001, 5'b00000, 1'b1, 1'b1, 64'h100, 64'h10);
    tick;
    chk_rdy("bp_a", 1'b1);
    chk_out("bp_a", 1'b1, 1'b1, 64'h110, 1'b0, 1'b0);
    put(1'b1, 3'b100, 5'b01000, 1'b1, 1'b0, 64'h200, 64'hFFFF_FFFF_FFFF_FFF8);
    tick;
    chk_rdy("bp_b", 1'b0);
    chk_out("bp_b", 1'b1, 1'b1, 64'h110, 1'b0, 1'b0);
    put(1'b1, 3'b111, 5'b00000, 1'b1, 1'b1, 64'h300, 64'h50);
    tick;
    chk_rdy("bp_c", 1'b0);
    chk_out("bp_c", 1'b1, 1'b1, 64'h110, 1'b0, 1'b0);
    chk_cnt("bp_c", 3, 2, 3, 2);
    in_ready = 1'b1;
    tick;
    chk_out("drain_b", 1'b1, 1'b1, 64'h1F8, 1'b1, 1'b0);
    chk_rdy("drain_b", 1'b1);
    chk_cnt("drain_a", 4, 2, 3, 2);
    tick;
    in_valid = 1'b0;
    chk_out("drain_c", 1'b1, 1'b0, 64'h304, 1'b1, 1'b0);
    chk_cnt("drain_b", 5, 3, 3, 3);
    tick;
    chk_out("drain_end", 1'b0, 1'b0, 64'h304, 1'b1, 1'b0);
    chk_cnt("drain_c", 6, 4, 3, 3);

    // flush with both entries full and a same-cycle entry
    in_ready = 1'b0;
    put(1'b1, 3'b000, 5'b10000, 1'b1, 1'b0, 64'h400, 64'h4);
    tick;
    put(1'b1, 3'b000, 5'b10000, 1'b1, 1'b0, 64'h500, 64'h4);
    tick;
    chk_rdy("pre_flush", 1'b0);
    put(1'b1, 3'b000, 5'b10000, 1'b1, 1'b0, 64'h600, 64'h4);
    in_flush = 1'b1;
    tick;
    chk("flush.valid", 64'(out_valid), 64'h0);
    chk_rdy("flush", 1'b1);
    chk_cnt("flush", 6, 4, 3, 3);

    // flush dominates in_valid while ready
    in_ready = 1'b1;
    tick;
    chk("flush_dom.valid", 64'(out_valid), 64'h0);
    in_flush = 1'b0;
    in_valid = 1'b0;
    tick;
    chk("flush_dom.later", 64'(out_valid), 64'h0);
    chk_cnt("flush_dom", 6, 4, 3, 3);

    // a retirement in the flush cycle still counts
    in_ready = 1'b0;
    put(1'b1, 3'b000, 5'b10000, 1'b1, 1'b0, 64'h700, 64'h8);
    tick;
    in_valid = 1'b0;
    chk_out("pre_flush_ret", 1'b1, 1'b1, 64'h708, 1'b1, 1'b0);
    in_ready = 1'b1;
    in_flush = 1'b1;
    tick;
    in_flush = 1'b0;
    chk("flush_ret.valid", 64'(out_valid), 64'h0);
    chk_cnt("flush_ret", 7, 5, 3, 3);

    // async reset between edges discards a buffered entry
    in_ready = 1'b0;
    put(1'b1, 3'b000, 5'b10000, 1'b1, 1'b0, 64'h800, 64'h10);
    tick;
    in_valid = 1'b0;
    chk_out("pre_rst", 1'b1, 1'b1, 64'h810, 1'b1, 1'b0);
    #2;
    in_rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
    chk_rdy("async_rst", 1'b1);
    chk_cnt("async_rst", 0, 0, 0, 0);
    @(negedge in_clk);
    in_rst_n = 1'b1;
    in_ready = 1'b1;
    put(1'b1, 3'b101, 5'b00010, 1'b1, 1'b1, 64'h900, 64'h30);
    tick;
    in_valid = 1'b0;
    chk_out("post_rst", 1'b1, 1'b1, 64'h930, 1'b0, 1'b0);
    tick;
    chk_cnt("post_rst", 1, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
